// File: rtl/macc_pkg.sv
// ============================================================================
//  Module   : macc_pkg
//  Brief    : Shared MACC datapath constants and FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package macc_pkg;

    localparam int MACC_OPW = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tc_bit_cell.sv
// ============================================================================
//  Module   : tc_bit_cell
//  Brief    : One-bit copy-until-first-one / invert-thereafter decode cell.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_bit_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic neg,
    input  logic b,
    output logic r
);

    logic r_seen_one;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_seen_one <= 1'b0;
        end else if (en && neg && b) begin
            r_seen_one <= 1'b1;
        end
    end

    // The first one of a negative word is copied; only later bits invert.
    assign r = b ^ (neg & r_seen_one);

endmodule

`default_nettype wire

// File: rtl/tc2sm_serial.sv
// ============================================================================
//  Module   : tc2sm_serial
//  Brief    : Bit-serial two's-complement to sign-magnitude converter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc2sm_serial
    import macc_pkg::*;
#(
    parameter int W = MACC_OPW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sign,
    output logic [W-1:0] out_mag,
    output logic         busy
);

    localparam int                  c_CNT_W = $clog2(W);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(W - 1);

    state_t               r_state;
    state_t               w_next;
    logic [W-1:0]         r_sreg;
    logic [W-1:0]         r_mag;
    logic                 r_sign;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_accept;
    logic                 w_shift;
    logic                 w_last;
    logic                 w_bit;

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_shift   = (r_state == ST_SHIFT);
    assign w_last    = (r_cnt == c_LAST);

    assign out_valid = (r_state == ST_DONE);
    assign out_sign  = r_sign;
    assign out_mag   = r_mag;
    assign busy      = (r_state != ST_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)  w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    tc_bit_cell u_cell (
        .clk (clk),
        .rst (rst),
        .clr (w_accept),
        .en  (w_shift),
        .neg (r_sign),
        .b   (r_sreg[0]),
        .r   (w_bit)
    );

    // Magnitude fills from the top so bit 0 lands in place after W shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
            r_mag  <= '0;
            r_sign <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_sreg <= in_data;
            r_sign <= in_data[W-1];
            r_cnt  <= '0;
        end else if (w_shift) begin
            r_sreg <= {1'b0, r_sreg[W-1:1]};
            r_mag  <= {w_bit, r_mag[W-1:1]};
            r_cnt  <= w_last ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tc2sm_serial.sv
// ============================================================================
//  Module   : tb_tc2sm_serial
//  Brief    : Scoreboard bench for the serial two's-complement decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tc2sm_serial;

    localparam int W = 5;

    typedef struct packed {
        logic         s;
        logic [W-1:0] m;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         busy;

    int   n_err = 0;
    int   n_chk = 0;
    exp_t q[$];

    int   cyc       = 0;
    int   acc_cyc   = -100;
    int   last_acc  = -100;
    int   b2b_from  = 1 << 30;
    bit   prev_hs   = 1'b0;
    bit   prev_vld  = 1'b0;
    bit   stall     = 1'b0;
    exp_t held;

    tc2sm_serial #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_model(input logic [W-1:0] d);
        exp_t         e;
        logic [W-1:0] t;
        t   = ~d;
        t   = t + 1'b1;
        e.s = d[W-1];
        e.m = d[W-1] ? t : d;
        return e;
    endfunction

    // Monitor samples on the falling edge, between driver updates.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
            prev_hs  = 1'b0;
            prev_vld = 1'b0;
            stall    = 1'b0;
        end else begin
            if (prev_hs) begin
                check_val("no_dup_out", out_valid, 0);
                check_val("rdy_after_hs", in_ready, 1);
            end
            if (out_valid && !prev_vld)
                check_val("latency", cyc - acc_cyc, W + 1);
            if (out_valid)
                check_val("rdy_low_done", in_ready, 0);
            if (out_valid && !out_ready) begin
                if (stall) begin
                    check_val("hold_sign", out_sign, held.s);
                    check_val("hold_mag", out_mag, held.m);
                end else begin
                    held  = '{out_sign, out_mag};
                    stall = 1'b1;
                end
            end else begin
                stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val("spurious_out", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    check_val("sign", out_sign, e.s);
                    check_val("mag", out_mag, e.m);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_model(in_data));
                if (last_acc >= b2b_from)
                    check_val("throughput_gap", cyc - last_acc, W + 2);
                last_acc = cyc;
                acc_cyc  = cyc;
            end
            prev_hs  = out_valid && out_ready;
            prev_vld = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] d);
        int n;
        bit acc;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check_val("accept_timeout", acc, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("drain_busy", busy, 0);
    endtask

    initial begin
        logic [W-1:0] vec [6];
        vec = '{5'b11101, 5'b10000, 5'b11111, 5'b00000, 5'b01111, 5'b00110};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_sign", out_sign, 0);
        check_val("rst_out_mag", out_mag, 0);
        rst = 1'b0;
        #1;
        check_val("post_rst_ready", in_ready, 1);

        // Reset at E2 discards the word in flight.
        send(5'b10110);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_val("midrst_ready", in_ready, 1);
        check_val("midrst_busy", busy, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_val("midrst_no_valid", out_valid, 0);
        end
        send(5'b10110);
        in_valid = 1'b0;
        drain();

        // Basic negative plus the boundary words, consumer always ready.
        for (int i = 0; i < 6; i++) send(vec[i]);
        in_valid = 1'b0;
        drain();

        // Backpressure with a toggling producer.
        out_ready = 1'b0;
        send(5'b10011);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 50) begin
                in_data = W'($urandom);
                @(posedge clk); #1;
                n++;
            end
            check_val("bp_valid_seen", out_valid, 1);
        end
        for (int i = 0; i < 10; i++) begin
            in_data = W'($urandom);
            @(posedge clk); #1;
            check_val("bp_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        send(5'b01010);
        in_valid = 1'b0;
        drain();

        // Exhaustive back-to-back sweep.
        b2b_from = cyc;
        for (int i = 0; i < (1 << W); i++) send(W'(i));
        in_valid = 1'b0;
        drain();
        b2b_from = 1 << 30;

        repeat (3) @(posedge clk);
        #1;
        check_val("sb_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
